// File: rtl/fetch_queue.sv
// fetch_queue
//   Dual-issue fetch stage. Each cycle it may issue the (pcF1, pcF2) pair to a
//   1-cycle-latency instruction memory, then captures the returned instruction
//   pair together with its PCs in a DEPTH-entry FIFO that decode drains with
//   a valid/ready handshake. Issue is credit based: the in-flight pair counts
//   against FIFO space, so a correctly sequenced stream never overflows.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   pcF1, pcF2                  slot A / slot B PCs from the next-PC logic
//   flush                       redirect: drop buffered and in-flight pairs
//   fetch_hold                  PC logic must hold pcF1/pcF2 this cycle
//   imem_req                    memory read strobe
//   imem_addr_a, imem_addr_b    memory addresses (pass-through of pcF1/pcF2)
//   imem_rdata_a, imem_rdata_b  words for the addresses of the previous cycle
//   dec_valid, dec_ready        decode handshake
//   dec_pcA/instA/pcB/instB     head entry fields
//   err_overflow                sticky: push attempted while full
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pcF1,
  input  logic [31:0] pcF2,
  input  logic        flush,
  output logic        fetch_hold,
  output logic        imem_req,
  output logic [31:0] imem_addr_a,
  output logic [31:0] imem_addr_b,
  input  logic [31:0] imem_rdata_a,
  input  logic [31:0] imem_rdata_b,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pcA,
  output logic [31:0] dec_instA,
  output logic [31:0] dec_pcB,
  output logic [31:0] dec_instB,
  output logic        err_overflow
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          inflight;
  logic [31:0]   pend_pcA;
  logic [31:0]   pend_pcB;

  logic [31:0] st_pcA   [DEPTH];
  logic [31:0] st_instA [DEPTH];
  logic [31:0] st_pcB   [DEPTH];
  logic [31:0] st_instB [DEPTH];

  logic [AW:0] occ;
  logic        issue;
  logic        full;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        overflow;

  // Occupancy includes the pair still in the memory pipeline; that credit is
  // what keeps the returning data from ever finding the FIFO full.
  assign occ   = count + {{AW{1'b0}}, inflight};
  assign issue = rst_n && !flush && (occ < DEPTH_C);

  assign fetch_hold  = !issue;
  assign imem_req    = issue;
  assign imem_addr_a = pcF1;
  assign imem_addr_b = pcF2;

  assign full      = (count == DEPTH_C);
  assign dec_valid = (count != '0);
  assign pop       = dec_valid && dec_ready && !flush;
  assign push_req  = inflight && !flush;
  // A pop in the same cycle frees the head slot, so a push at full is legal then.
  assign push      = push_req && (!full || pop);
  assign overflow  = push_req && full && !pop;

  assign dec_pcA   = st_pcA[rd_ptr];
  assign dec_instA = st_instA[rd_ptr];
  assign dec_pcB   = st_pcB[rd_ptr];
  assign dec_instB = st_instB[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      inflight     <= 1'b0;
      pend_pcA     <= RESET_PC;
      pend_pcB     <= RESET_PC;
      err_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        st_pcA[i]   <= RESET_PC;
        st_instA[i] <= '0;
        st_pcB[i]   <= RESET_PC;
        st_instB[i] <= '0;
      end
    end else if (flush) begin
      // Clearing inflight here is what discards the data returning next cycle.
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pend_pcA <= pcF1;
        pend_pcB <= pcF2;
      end
      if (push) begin
        st_pcA[wr_ptr]   <= pend_pcA;
        st_instA[wr_ptr] <= imem_rdata_a;
        st_pcB[wr_ptr]   <= pend_pcB;
        st_instB[wr_ptr] <= imem_rdata_b;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (overflow) begin
        err_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Directed bench for fetch_queue. A registered memory model returns
//   addr ^ 32'hAAAA one cycle after the address. Every issued pair is pushed
//   to a scoreboard queue with its expected instructions; every decode
//   handshake pops and compares the head fields.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0001_0000;
  localparam logic [31:0] KEY      = 32'h0000_AAAA;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pcF1, pcF2;
  logic        flush;
  logic        fetch_hold, imem_req;
  logic [31:0] imem_addr_a, imem_addr_b;
  logic [31:0] imem_rdata_a, imem_rdata_b;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_pcA, dec_instA, dec_pcB, dec_instB;
  logic        err_overflow;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pcF1         (pcF1),
    .pcF2         (pcF2),
    .flush        (flush),
    .fetch_hold   (fetch_hold),
    .imem_req     (imem_req),
    .imem_addr_a  (imem_addr_a),
    .imem_addr_b  (imem_addr_b),
    .imem_rdata_a (imem_rdata_a),
    .imem_rdata_b (imem_rdata_b),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_pcA      (dec_pcA),
    .dec_instA    (dec_instA),
    .dec_pcB      (dec_pcB),
    .dec_instB    (dec_instB),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata_a <= imem_addr_a ^ KEY;
    imem_rdata_b <= imem_addr_b ^ KEY;
  end

  typedef struct {
    logic [31:0] pcA;
    logic [31:0] instA;
    logic [31:0] pcB;
    logic [31:0] instB;
  } pair_t;

  pair_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_issue = 0;
  int n_pop = 0;
  int n_nonseq = 0;
  int first_issue = -1;
  int first_valid = -1;
  int guard;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare/push at the falling edge, then advance sequential PCs
  // just after the rising edge if the pair was accepted.
  task automatic cycle();
    pair_t e;
    logic  issued;
    @(negedge clk);
    if (rst_n && !flush && dec_valid && dec_ready) begin
      n_pop++;
      if (first_valid < 0) first_valid = cyc;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected_pair observed=pcA_%h expected=no_pair", dec_pcA);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pcA", dec_pcA, e.pcA);
        chk("sb_instA", dec_instA, e.instA);
        chk("sb_pcB", dec_pcB, e.pcB);
        chk("sb_instB", dec_instB, e.instB);
        if (e.pcB == 32'h0001_0400) n_nonseq++;
      end
    end
    issued = imem_req;
    if (imem_req) begin
      n_issue++;
      if (first_issue < 0) first_issue = cyc;
      exp_q.push_back('{pcF1, pcF1 ^ KEY, pcF2, pcF2 ^ KEY});
    end
    if (flush || !rst_n) exp_q.delete();
    @(posedge clk);
    #1;
    cyc++;
    if (issued) begin
      pcF2 = pcF1 + 32'd12;
      pcF1 = pcF1 + 32'd8;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    dec_ready = 1'b0;
    pcF1      = 32'h0;
    pcF2      = 32'h0;

    // Reset state
    cycle();
    chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_err", {31'b0, err_overflow}, 32'd0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_hold", {31'b0, fetch_hold}, 32'd1);
    cycle();
    rst_n = 1'b1;
    pcF1  = 32'h0001_0000;
    pcF2  = 32'h0001_0004;
    #1;
    chk("post_rst_pcA", dec_pcA, RESET_PC);
    chk("post_rst_pcB", dec_pcB, RESET_PC);
    chk("post_rst_instA", dec_instA, 32'd0);
    chk("post_rst_instB", dec_instB, 32'd0);

    // Basic stream
    dec_ready   = 1'b1;
    n_pop       = 0;
    first_issue = -1;
    first_valid = -1;
    repeat (10) cycle();
    chk("stream_latency", 32'(first_valid - first_issue), 32'd2);
    chk("stream_no_bubble", 32'(n_pop), 32'd8);

    // Backpressure fill from an empty queue
    flush     = 1'b1;
    dec_ready = 1'b0;
    pcF1      = 32'h0001_0100;
    pcF2      = 32'h0001_0104;
    cycle();
    flush   = 1'b0;
    n_issue = 0;
    repeat (12) cycle();
    chk("bp_issue_count", 32'(n_issue), 32'd4);
    chk("bp_hold", {31'b0, fetch_hold}, 32'd1);
    chk("bp_valid", {31'b0, dec_valid}, 32'd1);
    dec_ready = 1'b1;
    n_issue   = 0;
    cycle();
    chk("bp_first_pop_no_issue", 32'(n_issue), 32'd0);
    chk("bp_reissue_next", {31'b0, fetch_hold}, 32'd0);
    repeat (12) cycle();
    chk("bp_err", {31'b0, err_overflow}, 32'd0);

    // Non-sequential pair
    guard = 0;
    while (fetch_hold && guard < 10) begin
      cycle();
      guard++;
    end
    chk("ns_issue_ready", {31'b0, fetch_hold}, 32'd0);
    pcF1     = 32'h0001_0020;
    pcF2     = 32'h0001_0400;
    n_nonseq = 0;
    repeat (6) cycle();
    chk("ns_seen", 32'(n_nonseq), 32'd1);

    // Flush with 3 buffered + 1 in flight
    dec_ready = 1'b0;
    guard     = 0;
    while (!fetch_hold && guard < 10) begin
      cycle();
      guard++;
    end
    chk("fl_filled_hold", {31'b0, fetch_hold}, 32'd1);
    chk("fl_filled_valid", {31'b0, dec_valid}, 32'd1);
    flush = 1'b1;
    pcF1  = 32'h0002_0000;
    pcF2  = 32'h0002_0004;
    cycle();
    flush = 1'b0;
    #1;
    chk("fl_valid_t1", {31'b0, dec_valid}, 32'd0);
    chk("fl_issue_t1", {31'b0, imem_req}, 32'd1);
    dec_ready = 1'b1;
    cycle();
    chk("fl_valid_t2", {31'b0, dec_valid}, 32'd0);
    cycle();
    chk("fl_valid_t3", {31'b0, dec_valid}, 32'd1);
    chk("fl_redirect_pcA", dec_pcA, 32'h0002_0000);
    repeat (4) cycle();

    // Reset mid-operation with 2 entries buffered
    dec_ready = 1'b0;
    cycle();
    chk("mr_two_buffered_valid", {31'b0, dec_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("mr_rst_hold", {31'b0, fetch_hold}, 32'd1);
    cycle();
    rst_n = 1'b1;
    pcF1  = 32'h0001_0000;
    pcF2  = 32'h0001_0004;
    #1;
    chk("mr_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("mr_pcA", dec_pcA, RESET_PC);
    chk("mr_err", {31'b0, err_overflow}, 32'd0);
    dec_ready = 1'b1;
    n_pop     = 0;
    repeat (10) cycle();
    chk("mr_stream_pops", 32'(n_pop), 32'd8);
    chk("final_err", {31'b0, err_overflow}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
